// File: rtl/rv32i_control.sv
// Multicycle control FSM for the RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Outputs are decoded from the state register and are forced to idle defaults while rst_n is low.
module rv32i_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic       mem_resp,
  input  logic [1:0] mem_addr_lo,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       halted
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_IMM   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_REG   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OP_BR    = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] CMP_BEQ  = 3'b000;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR,
    JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2, TRAP
  } state_t;

  state_t state, state_next;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH1;
    else        state <= state_next;
  end

  // Next-state and output decode
  always_comb begin
    state_next      = state;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = 2'd0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = 3'd0;
    regfilemux_sel  = 4'd0;
    marmux_sel      = 1'b0;
    cmpmux_sel      = 1'b0;
    aluop           = ALU_ADD;
    cmpop           = CMP_BEQ;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    halted          = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH1: begin
          load_mar   = 1'b1;
          state_next = FETCH2;
        end
        FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_next = FETCH3;
        end
        FETCH3: begin
          load_ir    = 1'b1;
          state_next = DECODE;
        end
        DECODE: begin
          case (opcode)
            OP_IMM:            state_next = IMM;
            OP_REG:            state_next = REG;
            OP_LUI:            state_next = LUI;
            OP_AUIPC:          state_next = AUIPC;
            OP_BR:             state_next = BR;
            OP_JAL:            state_next = JAL;
            OP_JALR:           state_next = JALR;
            OP_LOAD, OP_STORE: state_next = CALC_ADDR;
            default:           state_next = TRAP;
          endcase
        end
        IMM, REG: begin
          alumux2_sel = (state == REG) ? 3'd5 : 3'd0;
          case (funct3)
            3'b010, 3'b011: begin
              cmpmux_sel     = (state == IMM);
              cmpop          = funct3[0] ? CMP_BLTU : CMP_BLT;
              regfilemux_sel = 4'd1;
            end
            3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b000:  aluop = ((state == REG) && funct7[5]) ? ALU_SUB : ALU_ADD;
            default: aluop = funct3;
          endcase
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = FETCH1;
        end
        LUI, AUIPC: begin
          if (state == LUI) begin
            regfilemux_sel = 4'd2;
          end else begin
            alumux1_sel = 1'b1;
            alumux2_sel = 3'd1;
          end
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = FETCH1;
        end
        BR: begin
          cmpop       = funct3;
          alumux1_sel = 1'b1;
          alumux2_sel = 3'd2;
          pcmux_sel   = br_en ? 2'd1 : 2'd0;
          load_pc     = 1'b1;
          state_next  = FETCH1;
        end
        JAL, JALR: begin
          regfilemux_sel = 4'd4;
          load_regfile   = 1'b1;
          alumux1_sel    = (state == JAL);
          alumux2_sel    = (state == JAL) ? 3'd4 : 3'd0;
          pcmux_sel      = (state == JAL) ? 2'd1 : 2'd2;
          load_pc        = 1'b1;
          state_next     = FETCH1;
        end
        CALC_ADDR: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          if (opcode == OP_STORE) begin
            alumux2_sel   = 3'd3;
            load_data_out = 1'b1;
            state_next    = ST1;
          end else begin
            state_next = LD1;
          end
        end
        LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_next = LD2;
        end
        LD2: begin
          case (funct3)
            3'b000:  regfilemux_sel = 4'd5;
            3'b001:  regfilemux_sel = 4'd7;
            3'b100:  regfilemux_sel = 4'd6;
            3'b101:  regfilemux_sel = 4'd8;
            default: regfilemux_sel = 4'd3;
          endcase
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = FETCH1;
        end
        ST1: begin
          mem_write = 1'b1;
          case (funct3)
            3'b000:  mem_byte_enable = 4'(4'b0001 << mem_addr_lo);
            3'b001:  mem_byte_enable = 4'(4'b0011 << mem_addr_lo);
            default: mem_byte_enable = 4'b1111;
          endcase
          if (mem_resp) state_next = ST2;
        end
        ST2: begin
          load_pc    = 1'b1;
          state_next = FETCH1;
        end
        TRAP:    halted = 1'b1;
        default: state_next = FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_control.sv
// Randomized self-checking bench for rv32i_control: an instruction-level model predicts the
// control word of every cycle, including memory stalls, traps and resets.
module tb_rv32i_control;

  logic       clk, rst_n;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       br_en, mem_resp;
  logic [1:0] mem_addr_lo;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel;
  logic       alumux1_sel, marmux_sel, cmpmux_sel;
  logic [2:0] alumux2_sel, aluop, cmpop;
  logic [3:0] regfilemux_sel, mem_byte_enable;
  logic       mem_read, mem_write, halted;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux;
    logic       alumux1;
    logic [2:0] alumux2;
    logic [3:0] regfilemux;
    logic       marmux, cmpmux;
    logic [2:0] aluop, cmpop;
    logic       mem_read, mem_write;
    logic [3:0] be;
    logic       halted;
  } ctl_t;

  localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;

  logic [6:0] legal_ops [9] = '{OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR,
                                OP_LOAD, OP_STORE};
  int load_sel [8] = '{5, 7, 3, 3, 6, 8, 3, 3};
  logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  rv32i_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem_resp(mem_resp), .mem_addr_lo(mem_addr_lo),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile), .load_mar(load_mar),
    .load_mdr(load_mdr), .load_data_out(load_data_out), .pcmux_sel(pcmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .regfilemux_sel(regfilemux_sel),
    .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel), .aluop(aluop), .cmpop(cmpop),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t dflt();
    ctl_t c = '0;
    c.be = 4'hF;
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.load_pc = load_pc; c.load_ir = load_ir; c.load_regfile = load_regfile;
    c.load_mar = load_mar; c.load_mdr = load_mdr; c.load_data_out = load_data_out;
    c.pcmux = pcmux_sel; c.alumux1 = alumux1_sel; c.alumux2 = alumux2_sel;
    c.regfilemux = regfilemux_sel; c.marmux = marmux_sel; c.cmpmux = cmpmux_sel;
    c.aluop = aluop; c.cmpop = cmpop; c.mem_read = mem_read; c.mem_write = mem_write;
    c.be = mem_byte_enable; c.halted = halted;
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (op=%b f3=%b f7=%b) t=%0t",
               tag, got, exp, opcode, funct3, funct7, $time);
    end
  endtask

  // Check the current cycle's control word, then advance to the next negedge.
  task automatic step(input string tag, input ctl_t exp, input logic resp);
    mem_resp = resp;
    #1;
    check_eq(tag, 32'(observe()), 32'(exp));
    @(negedge clk);
  endtask

  task automatic mem_wait(input string tag, input ctl_t exp, input int delay);
    for (int i = 0; i < delay; i++) step(tag, exp, 1'b0);
    step(tag, exp, 1'b1);
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  // Behavioural meaning of arithmetic/logic instructions, in the ALU's encoding
  function automatic logic [2:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'd0:    return (is_reg && alt) ? 3'b011 : 3'b000;
      3'd1:    return 3'b001;
      3'd4:    return 3'b100;
      3'd5:    return alt ? 3'b010 : 3'b101;
      3'd6:    return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic ctl_t exec_exp(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic br);
    ctl_t c = dflt();
    case (op)
      OP_IMM, OP_REG: begin
        c.alumux2 = (op == OP_REG) ? 3'd5 : 3'd0;
        if (f3 == 3'd2 || f3 == 3'd3) begin
          c.regfilemux = 4'd1;
          c.cmpmux     = (op == OP_IMM);
          c.cmpop      = (f3 == 3'd2) ? 3'b100 : 3'b110;
        end else begin
          c.aluop = alu_code(f3, f7[5], op == OP_REG);
        end
        c.load_regfile = 1'b1; c.load_pc = 1'b1;
      end
      OP_LUI: begin
        c.regfilemux = 4'd2; c.load_regfile = 1'b1; c.load_pc = 1'b1;
      end
      OP_AUIPC: begin
        c.alumux1 = 1'b1; c.alumux2 = 3'd1; c.load_regfile = 1'b1; c.load_pc = 1'b1;
      end
      OP_BR: begin
        c.cmpop = f3; c.alumux1 = 1'b1; c.alumux2 = 3'd2; c.load_pc = 1'b1;
        c.pcmux = br ? 2'd1 : 2'd0;
      end
      OP_JAL: begin
        c.regfilemux = 4'd4; c.load_regfile = 1'b1; c.alumux1 = 1'b1; c.alumux2 = 3'd4;
        c.pcmux = 2'd1; c.load_pc = 1'b1;
      end
      default: begin
        c.regfilemux = 4'd4; c.load_regfile = 1'b1; c.pcmux = 2'd2; c.load_pc = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Run one whole instruction from FETCH1, predicting every cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic br, input logic [1:0] lo,
                           input int d_fetch, input int d_mem, input int trap_cycles);
    ctl_t e;
    int   mask;
    opcode = op; funct3 = f3; funct7 = f7; br_en = br; mem_addr_lo = lo;
    e = dflt(); e.load_mar = 1'b1;
    step({name, ".fetch1"}, e, noise());
    e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
    mem_wait({name, ".fetch2"}, e, d_fetch);
    e = dflt(); e.load_ir = 1'b1;
    step({name, ".fetch3"}, e, noise());
    step({name, ".decode"}, dflt(), noise());
    if (op == OP_LOAD || op == OP_STORE) begin
      e = dflt(); e.marmux = 1'b1; e.load_mar = 1'b1;
      e.alumux2 = (op == OP_STORE) ? 3'd3 : 3'd0;
      e.load_data_out = (op == OP_STORE);
      step({name, ".calc_addr"}, e, noise());
      if (op == OP_LOAD) begin
        e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
        mem_wait({name, ".ld1"}, e, d_mem);
        e = dflt(); e.regfilemux = 4'(load_sel[f3]); e.load_regfile = 1'b1; e.load_pc = 1'b1;
        step({name, ".ld2"}, e, noise());
      end else begin
        mask = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 3 : 15;
        e = dflt(); e.mem_write = 1'b1;
        e.be = (f3 > 3'd1) ? 4'hF : 4'((mask * (2 ** int'(lo))) % 16);
        mem_wait({name, ".st1"}, e, d_mem);
        e = dflt(); e.load_pc = 1'b1;
        step({name, ".st2"}, e, noise());
      end
    end else if (is_legal(op)) begin
      step({name, ".exec"}, exec_exp(op, f3, f7, br), noise());
    end else begin
      e = dflt(); e.halted = 1'b1;
      for (int i = 0; i < trap_cycles; i++) step({name, ".trap"}, e, noise());
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq(tag, 32'(observe()), 32'(dflt()));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_instr();
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = legal_ops[$urandom_range(0, 8)];
    f3 = 3'($urandom_range(0, 7));
    f7 = {1'b0, 1'($urandom_range(0, 1)), 5'd0};
    if (op == OP_LOAD)  f3 = load_f3[$urandom_range(0, 4)];
    if (op == OP_STORE) f3 = 3'($urandom_range(0, 2));
    run_instr("rnd", op, f3, f7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
  endtask

  initial begin
    ctl_t e;
    logic [6:0] bad_op;
    rst_n = 1'b0; mem_resp = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    br_en = 1'b0; mem_addr_lo = '0;
    repeat (2) @(negedge clk);
    apply_reset("reset");

    run_instr("addi", OP_IMM, 3'b000, 7'd0, 1'b0, 2'd0, 0, 0, 0);
    run_instr("sub",  OP_REG, 3'b000, 7'b0100000, 1'b0, 2'd0, 0, 0, 0);
    run_instr("srai", OP_IMM, 3'b101, 7'b0100000, 1'b0, 2'd0, 1, 0, 0);
    run_instr("beq1", OP_BR, 3'b000, 7'd0, 1'b1, 2'd0, 0, 0, 0);
    run_instr("beq0", OP_BR, 3'b000, 7'd0, 1'b0, 2'd0, 0, 0, 0);
    run_instr("sb",   OP_STORE, 3'b000, 7'd0, 1'b0, 2'd2, 0, 2, 0);
    run_instr("sh3",  OP_STORE, 3'b001, 7'd0, 1'b0, 2'd3, 0, 0, 0);
    run_instr("sw",   OP_STORE, 3'b010, 7'd0, 1'b0, 2'd1, 0, 1, 0);
    run_instr("lhu",  OP_LOAD, 3'b101, 7'd0, 1'b0, 2'd0, 0, 0, 0);
    run_instr("lb",   OP_LOAD, 3'b000, 7'd0, 1'b0, 2'd0, 2, 3, 0);
    run_instr("sltiu", OP_IMM, 3'b011, 7'd0, 1'b0, 2'd0, 0, 0, 0);
    run_instr("slt",  OP_REG, 3'b010, 7'd0, 1'b0, 2'd0, 0, 0, 0);

    // Reset while FETCH2 is waiting on memory
    opcode = OP_IMM; funct3 = 3'b000; funct7 = 7'd0;
    e = dflt(); e.load_mar = 1'b1;
    step("rstmid.fetch1", e, 1'b0);
    e = dflt(); e.mem_read = 1'b1; e.load_mdr = 1'b1;
    mem_resp = 1'b0;
    #1;
    check_eq("rstmid.fetch2", 32'(observe()), 32'(e));
    #2;
    apply_reset("rstmid.drop");
    run_instr("after_rst", OP_LUI, 3'b000, 7'd0, 1'b0, 2'd0, 0, 0, 0);

    for (int i = 0; i < 150; i++) random_instr();

    run_instr("trap", 7'b1111111, 3'b000, 7'd0, 1'b0, 2'd0, 1, 0, 6);
    apply_reset("rst_trap");
    do bad_op = 7'($urandom_range(0, 127)); while (is_legal(bad_op));
    run_instr("trap_rnd", bad_op, 3'($urandom_range(0, 7)), 7'd0, 1'b0, 2'd0, 0, 0, 3);
    apply_reset("rst_trap2");
    run_instr("final", OP_JALR, 3'b000, 7'd0, 1'b0, 2'd0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
